pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//   Central sequencer for the 5-stage pipeline. Tracks a valid bit per stage (ID/EX/MEM/WB).
//   Produces stall, bubble, flush and redirect controls from three sources:
//   - load-use hazards
//   - multi-cycle data-memory waits
//   - taken branches resolved in writeback
//   Also drains and halts the core on HLT. The writeback stage commits only when wb_valid=1.
// PARAMETERS
//   REG_AW  4   register-address width
//   CNT_W   16  perf counter width (used only with PIPE_PERF_EN)
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst_n         in   1      asynchronous active-low reset
//   id_rs,id_rt   in   REG_AW source regs of the instruction in ID
//   id_uses_rs/rt in   1      ID instruction actually reads rs / rt
//   id_halt       in   1      ID instruction is HLT
//   ex_rd         in   REG_AW destination reg of the instruction in EX
//   ex_mem_read   in   1      EX instruction is a load
//   mem_req       in   1      MEM instruction accesses data memory
//   mem_ready     in   1      data memory completes the access this cycle
//   wb_halt       in   1      WB instruction is HLT
//   wb_branch     in   1      WB should_branch result (next_pc = target)
//   pc_we         out  1      PC register write enable
//   if_id_we      out  1      IF/ID register write enable
//   pc_redirect   out  1      select next_pc from writeback instead of pc+2
//   mem_abort     out  1      cancel the in-flight data-memory access
//   id_valid,ex_valid,mem_valid,wb_valid  out 1  stage valid bits (registered)
//   halted        out  1      core halted (registered)
// BEHAVIOUR
//   Reset: all valid bits 0, halted 0, FSM=RUN. Outputs are combinational from state and inputs:
//     pc_we=1, if_id_we=1, pc_redirect=0, mem_abort=0.
//   Qualifiers:
//     br   = wb_valid & wb_branch
//     mst  = mem_valid & mem_req & ~mem_ready
//     lu   = ex_valid & ex_mem_read & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))
//   Priority: br > mst > lu > halt handling; exactly one action per cycle.
//   br: pc_redirect=1, pc_we=1, mem_abort=mst.
//     Next cycle: id/ex/mem/wb valid all 0. FSM->RUN, even from DRAIN.
//     Branch penalty is 4 cycles before the target commits.
//   mst: pc_we=0, if_id_we=0. ID/EX/MEM hold; wb_valid<=0 (bubble).
//     The current WB still commits exactly once.
//   lu: pc_we=0, if_id_we=0, ex_valid<=0 (bubble). MEM/WB advance.
//     Exactly 1 stall cycle per load-use pair.
//   Normal advance: wb<=mem, mem<=ex, ex<=id.
//     id_valid<=1 in RUN; id_valid<=0 in DRAIN/HALTED.
//   FSM states:
//     RUN: id_valid & id_halt & no stall -> DRAIN. HLT advances to EX; pc_we=0, if_id_we=0 afterwards.
//     DRAIN: no fetch. wb_valid & wb_halt & ~br -> HALTED. br -> RUN with flush.
//     HALTED: all valids 0, pc_we=if_id_we=0, halted=1. Exit only via rst_n.
//   Simultaneous:
//     br with lu: flush only, no stall.
//     mst with lu: mst only, lu is re-evaluated next cycle.
//     wb_halt with wb_branch: impossible encoding; branch wins.
//   Async reset mid-stall or mid-drain returns to reset state immediately; no partial commit.
// CONFIGURATION
//   PIPE_PERF_EN defined: adds outputs stall_cnt, flush_cnt, retire_cnt, each CNT_W bits.
//     Saturating, reset to 0, frozen while halted.
//     stall_cnt += cycles with (mst|lu); flush_cnt += br events; retire_cnt += wb_valid cycles.
//   Not defined: ports and counters absent; control behaviour identical.
// TESTING
//   Reset then idle: 4 cycles after rst_n rises, id..wb_valid = 1111.
//     pc_we=1 throughout, halted=0.
//   LW R1 then ADD R2,R1,R3: exactly 1 cycle pc_we=0 and ex_valid=0.
//     ADD reaches WB 1 cycle later than unstalled.
//   Load with mem_ready low 3 cycles: pc_we=0 for 3 cycles, wb_valid=0 for 3 cycles.
//     The older WB instruction commits exactly once.
//   Taken branch in WB with mst active: pc_redirect=1, mem_abort=1.
//     Next cycle valids = 0000; target's wb_valid rises 4 cycles later.
//   HLT preceded by a taken branch: branch flushes HLT, FSM stays RUN.
//     A plain HLT reaches WB and halted=1 with pc_we=0 thereafter.
//   PIPE_PERF_EN: the above sequence yields stall_cnt=4, flush_cnt=1.
//     Forcing 2^CNT_W stall cycles saturates stall_cnt at all-ones.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage valid tracking plus stall/bubble/flush/redirect control and HLT drain.
// Optional performance counters are enabled by defining PIPE_PERF_EN.
module pipeline_ctrl #(
  parameter int REG_AW = 4
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              wb_halt,
  input  logic              wb_branch,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              pc_redirect,
  output logic              mem_abort,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              halted
`ifdef PIPE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state, state_next;
  logic   id_n, ex_n, mem_n, wb_n;
  logic   br, mst, lu;

  assign br  = wb_valid & wb_branch;
  assign mst = mem_valid & mem_req & ~mem_ready;
  assign lu  = ex_valid & ex_mem_read & id_valid &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  assign halted = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      id_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      id_valid  <= id_n;
      ex_valid  <= ex_n;
      mem_valid <= mem_n;
      wb_valid  <= wb_n;
    end
  end

  always_comb begin
    state_next  = state;
    id_n        = id_valid;
    ex_n        = ex_valid;
    mem_n       = mem_valid;
    wb_n        = wb_valid;
    pc_we       = (state == RUN);
    if_id_we    = (state == RUN);
    pc_redirect = 1'b0;
    mem_abort   = 1'b0;

    if (br) begin
      pc_redirect = 1'b1;
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      mem_abort   = mst;
      id_n        = 1'b0;
      ex_n        = 1'b0;
      mem_n       = 1'b0;
      wb_n        = 1'b0;
      state_next  = RUN;
    end else if (mst) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      wb_n     = 1'b0;
    end else if (lu) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      ex_n     = 1'b0;
      mem_n    = ex_valid;
      wb_n     = mem_valid;
    end else begin
      unique case (state)
        RUN: begin
          // The HLT itself advances to EX, but nothing fetched behind it becomes valid.
          if (id_valid & id_halt) state_next = DRAIN;
          id_n  = (state_next == RUN);
          ex_n  = id_valid;
          mem_n = ex_valid;
          wb_n  = mem_valid;
        end
        DRAIN: begin
          if (wb_valid & wb_halt) begin
            state_next = HALTED;
            id_n  = 1'b0;
            ex_n  = 1'b0;
            mem_n = 1'b0;
            wb_n  = 1'b0;
          end else begin
            id_n  = 1'b0;
            ex_n  = id_valid;
            mem_n = ex_valid;
            wb_n  = mem_valid;
          end
        end
        default: begin
          id_n  = 1'b0;
          ex_n  = 1'b0;
          mem_n = 1'b0;
          wb_n  = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (state != HALTED) begin
      // A branch cycle is a flush, not a stall, even when mst/lu are also raised.
      if (~br & (mst | lu) & (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br & (flush_cnt != '1))               flush_cnt <= flush_cnt + CNT_W'(1);
      if (wb_valid & (retire_cnt != '1))        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven directed bench for pipeline_ctrl, plus hand-written drain/reset/saturation sequences.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_halt, ex_mem_read;
  logic       mem_req, mem_ready, wb_halt, wb_branch;
  logic       pc_we, if_id_we, pc_redirect, mem_abort;
  logic       id_valid, ex_valid, mem_valid, wb_valid, halted;
`ifdef PIPE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, retire_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_AW(4)
`ifdef PIPE_PERF_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_halt(wb_halt), .wb_branch(wb_branch),
    .pc_we(pc_we), .if_id_we(if_id_we), .pc_redirect(pc_redirect), .mem_abort(mem_abort),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .halted(halted)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    logic [3:0] rs, rt;
    logic       urs, urt, ih;
    logic [3:0] rd;
    logic       lmr, mreq, mrdy, wh, wbr;
    logic [3:0] exp_ctl;  // {pc_we, if_id_we, pc_redirect, mem_abort}
    logic [3:0] exp_v;    // {id, ex, mem, wb} valid before the next edge
    logic       exp_h;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [3:0] rs, logic [3:0] rt, logic urs, logic urt, logic ih,
                              logic [3:0] rd, logic lmr, logic mreq, logic mrdy, logic wh,
                              logic wbr, logic [3:0] ctl, logic [3:0] v, logic h);
    vec_t r;
    r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.ih = ih;
    r.rd = rd; r.lmr = lmr; r.mreq = mreq; r.mrdy = mrdy; r.wh = wh; r.wbr = wbr;
    r.exp_ctl = ctl; r.exp_v = v; r.exp_h = h;
    return r;
  endfunction

  function automatic vec_t idle(logic [3:0] ctl, logic [3:0] v, logic h);
    return mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ctl, v, h);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt; id_halt = v.ih;
    ex_rd = v.rd; ex_mem_read = v.lmr; mem_req = v.mreq; mem_ready = v.mrdy;
    wb_halt = v.wh; wb_branch = v.wbr;
  endtask

  // Called at a negedge: drive, settle, compare, then wait past one posedge.
  task automatic run_vec(input vec_t v, input string tag);
    apply(v);
    #1;
    chk({tag, " ctl"}, {28'd0, pc_we, if_id_we, pc_redirect, mem_abort}, {28'd0, v.exp_ctl});
    chk({tag, " valid"}, {28'd0, id_valid, ex_valid, mem_valid, wb_valid}, {28'd0, v.exp_v});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.exp_h});
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(idle(4'b1100, 4'b0000, 1'b0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned exp_retire;
    vec_t mstv;

    // Reset/fill, load-use on rs and rt, 3-cycle memory wait, mst+lu, branch+mst+lu,
    // branch flushing an HLT in ID, then a plain HLT draining to HALTED.
    vq.push_back(idle(4'b1100, 4'b0000, 0));
    vq.push_back(idle(4'b1100, 4'b1000, 0));
    vq.push_back(idle(4'b1100, 4'b1100, 0));
    vq.push_back(idle(4'b1100, 4'b1110, 0));
    vq.push_back(idle(4'b1100, 4'b1111, 0));
    vq.push_back(mk(4'd1, 4'd0, 1, 0, 0, 4'd1, 1, 0, 1, 0, 0, 4'b0000, 4'b1111, 0));
    vq.push_back(idle(4'b1100, 4'b1011, 0));
    vq.push_back(idle(4'b1100, 4'b1101, 0));
    vq.push_back(idle(4'b1100, 4'b1110, 0));
    vq.push_back(mk(4'd1, 4'd2, 0, 1, 0, 4'd1, 1, 0, 1, 0, 0, 4'b1100, 4'b1111, 0));
    vq.push_back(mk(4'd0, 4'd5, 0, 1, 0, 4'd5, 1, 0, 1, 0, 0, 4'b0000, 4'b1111, 0));
    vq.push_back(idle(4'b1100, 4'b1011, 0));
    vq.push_back(idle(4'b1100, 4'b1101, 0));
    vq.push_back(idle(4'b1100, 4'b1110, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 4'b0000, 4'b1111, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 4'b0000, 4'b1110, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 4'b0000, 4'b1110, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1, 0, 0, 4'b1100, 4'b1110, 0));
    vq.push_back(mk(4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 1, 0, 0, 0, 4'b0000, 4'b1111, 0));
    vq.push_back(mk(4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 1, 1, 0, 0, 4'b0000, 4'b1110, 0));
    vq.push_back(idle(4'b1100, 4'b1011, 0));
    vq.push_back(idle(4'b1100, 4'b1101, 0));
    vq.push_back(idle(4'b1100, 4'b1110, 0));
    vq.push_back(mk(4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 1, 0, 0, 1, 4'b1111, 4'b1111, 0));
    vq.push_back(idle(4'b1100, 4'b0000, 0));
    vq.push_back(idle(4'b1100, 4'b1000, 0));
    vq.push_back(idle(4'b1100, 4'b1100, 0));
    vq.push_back(idle(4'b1100, 4'b1110, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 1, 4'b1110, 4'b1111, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 0, 4'b1100, 4'b0000, 0));
    vq.push_back(idle(4'b1100, 4'b1000, 0));
    vq.push_back(idle(4'b1100, 4'b1100, 0));
    vq.push_back(idle(4'b1100, 4'b1110, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 0, 4'b1100, 4'b1111, 0));
    vq.push_back(idle(4'b0000, 4'b0111, 0));
    vq.push_back(idle(4'b0000, 4'b0011, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 1, 0, 4'b0000, 4'b0001, 0));
    vq.push_back(mk(4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 1));
    vq.push_back(idle(4'b0000, 4'b0000, 1));

    apply(idle(4'b1100, 4'b0000, 0));
    repeat (2) @(negedge clk);
    do_reset();
    exp_retire = 0;
    for (int i = 0; i < vq.size(); i++) begin
      if (i < vq.size() - 1) exp_retire += vq[i].exp_v[0];
      run_vec(vq[i], $sformatf("v%0d", i));
    end
`ifdef PIPE_PERF_EN
    // Counters sampled just after the last table edge: halted cycles add nothing.
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd7);
    chk("flush_cnt", {16'd0, flush_cnt}, 32'd2);
    chk("retire_cnt", {16'd0, retire_cnt}, exp_retire);
`endif

    // Taken branch while draining returns to RUN and refetches.
    do_reset();
    for (int i = 0; i < 4; i++) run_vec(idle(4'b1100, 4'(4'b1111 << (4 - i)), 0), "fill");
    run_vec(mk(4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 0, 4'b1100, 4'b1111, 0), "hlt_id");
    run_vec(mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 1, 4'b1110, 4'b0111, 0), "drain_br");
    run_vec(idle(4'b1100, 4'b0000, 0), "post_br");
    run_vec(idle(4'b1100, 4'b1000, 0), "refetch");
    run_vec(idle(4'b1100, 4'b1100, 0), "refill2");
    run_vec(idle(4'b1100, 4'b1110, 0), "refill3");

    // Asynchronous reset in the middle of a memory stall.
    mstv = mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 4'b0000, 4'b1111, 0);
    apply(mstv);
    #1;
    chk("mst_pc_we", {31'd0, pc_we}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {28'd0, id_valid, ex_valid, mem_valid, wb_valid}, 32'd0);
    chk("arst_pc_we", {31'd0, pc_we}, 32'd1);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PIPE_PERF_EN
    do_reset();
    for (int i = 0; i < 4; i++) run_vec(idle(4'b1100, 4'(4'b1111 << (4 - i)), 0), "sfill");
    apply(mstv);
    repeat (65540) @(negedge clk);
    #1;
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000ffff);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
